imm_enc: RTL and testbench

Immediate encoder: the inverse of `sz_ex`. It takes a 32-bit constant plus a target extend mode and produces the 20-bit immediate field(s) that `sz_ex` expands back to exactly that constant. A STANDARD value that does not fit in 12 bits is split into a U_TYPE + STANDARD pair, the LUI/ADDI materialisation. The block sits in the multi-cycle core's instruction-patch/materialisation path, with valid/ready handshakes on both sides.

---
 rtl/imm_enc_pkg.sv | 35 +++
 rtl/imm_fit_check.sv | 76 +++++++
 rtl/imm_enc.sv | 178 +++++++++++++++++
 tb/tb_imm_enc.sv | 496 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_enc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imm_enc_pkg
// Brief    : Shared widths and extend-mode encodings for sz_ex / imm_enc,
//            plus a helper that tests whether a value's upper bits are all
//            copies of the sign bit.
// Revision : 1.0 - initial release
// ============================================================================
package imm_enc_pkg;

    localparam int BUS_WIDTH       = 32;
    localparam int IMMEDIATE_WIDTH = 20;
    localparam int LO_WIDTH        = 12;

    // Extend-mode encodings understood by sz_ex.
    localparam logic [1:0] STANDARD = 2'b00;
    localparam logic [1:0] BRANCH   = 2'b01;
    localparam logic [1:0] U_TYPE   = 2'b10;
    localparam logic [1:0] JAL      = 2'b11;

    // True when v[BUS_WIDTH-1:lsb] are all equal, i.e. the value survives a
    // sign-extension from bit lsb.
    function automatic logic is_uniform(input logic [BUS_WIDTH-1:0] v, input int lsb);
        logic r;
        r = 1'b1;
        for (int i = 0; i < BUS_WIDTH; i++) begin
            if (i >= lsb && v[i] != v[BUS_WIDTH-1]) begin
                r = 1'b0;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_fit_check.sv
`default_nettype none
// ============================================================================
// Module   : imm_fit_check
// Brief    : Combinational classifier. Decides whether a constant can be
//            carried by one immediate field in the requested extend mode,
//            must be split into a LUI/ADDI-style pair, or cannot be encoded.
// Revision : 1.0 - initial release
// ============================================================================
module imm_fit_check
    import imm_enc_pkg::*;
(
    input  logic [BUS_WIDTH-1:0]       value,
    input  logic [1:0]                 mode,
    input  logic                       sel,
    output logic                       fits,
    output logic                       err,
    output logic                       split,
    output logic [IMMEDIATE_WIDTH-1:0] imm,
    output logic [IMMEDIATE_WIDTH-1:0] hi,
    output logic [LO_WIDTH-1:0]        lo
);

    localparam int c_pad_width = IMMEDIATE_WIDTH - LO_WIDTH;

    logic w_branch_range;

    // Classify the value against the chosen mode and build the field(s).
    always_comb begin
        fits           = 1'b0;
        err            = 1'b0;
        split          = 1'b0;
        imm            = '0;
        w_branch_range = 1'b0;
        lo             = value[LO_WIDTH-1:0];
        // ADDI sign-extends lo, so when lo[11] is set the upper part must be
        // bumped by one to cancel the borrowed 0x1000.
        hi             = value[BUS_WIDTH-1:LO_WIDTH]
                       + {{(IMMEDIATE_WIDTH-1){1'b0}}, value[LO_WIDTH-1]};

        case (mode)
            STANDARD: begin
                fits = sel ? is_uniform(value, 11) : ~|value[BUS_WIDTH-1:12];
                if (fits) begin
                    imm = {{c_pad_width{1'b0}}, value[11:0]};
                end else begin
                    split = 1'b1;
                end
            end
            BRANCH: begin
                w_branch_range = sel ? is_uniform(value, 12) : ~|value[BUS_WIDTH-1:13];
                err            = value[0] | ~w_branch_range;
                fits           = ~err;
                if (fits) begin
                    imm = {{c_pad_width{1'b0}}, value[12:1]};
                end
            end
            U_TYPE: begin
                err  = |value[11:0];
                fits = ~err;
                if (fits) begin
                    imm = value[BUS_WIDTH-1:12];
                end
            end
            default: begin
                // JAL: 21-bit signed, even offset.
                err  = value[0] | ~is_uniform(value, 20);
                fits = ~err;
                if (fits) begin
                    imm = value[20:1];
                end
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/imm_enc.sv
`default_nettype none
// ============================================================================
// Module   : imm_enc
// Brief    : Immediate encoder, the inverse of sz_ex. Accepts a constant and
//            a target extend mode, emits one beat (fits or error) or a
//            U_TYPE + STANDARD beat pair. Valid/ready on both sides, all
//            enc_* outputs registered.
// Revision : 1.0 - initial release
// ============================================================================
module imm_enc
    import imm_enc_pkg::*;
#(
    parameter int BUS_WIDTH       = imm_enc_pkg::BUS_WIDTH,
    parameter int IMMEDIATE_WIDTH = imm_enc_pkg::IMMEDIATE_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [BUS_WIDTH-1:0]       req_value,
    input  logic [1:0]                 req_mode,
    input  logic                       req_sel,
    output logic                       enc_valid,
    input  logic                       enc_ready,
    output logic [IMMEDIATE_WIDTH-1:0] enc_imm,
    output logic [1:0]                 enc_mode,
    output logic                       enc_sel,
    output logic                       enc_split,
    output logic                       enc_last,
    output logic                       enc_err
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_one  = 2'd1;
    localparam logic [1:0] c_st_hi   = 2'd2;
    localparam logic [1:0] c_st_lo   = 2'd3;

    localparam int c_pad_width = IMMEDIATE_WIDTH - LO_WIDTH;

    logic [1:0]                 r_state;
    logic [1:0]                 w_state_nxt;
    logic                       r_valid;
    logic                       w_valid_nxt;
    logic [IMMEDIATE_WIDTH-1:0] r_imm;
    logic [IMMEDIATE_WIDTH-1:0] w_imm_nxt;
    logic [1:0]                 r_mode;
    logic [1:0]                 w_mode_nxt;
    logic                       r_sel;
    logic                       w_sel_nxt;
    logic                       r_split;
    logic                       w_split_nxt;
    logic                       r_last;
    logic                       w_last_nxt;
    logic                       r_err;
    logic                       w_err_nxt;
    logic [LO_WIDTH-1:0]        r_lo;
    logic [LO_WIDTH-1:0]        w_lo_nxt;

    logic                       w_fire;
    logic                       w_fit_fits;
    logic                       w_fit_err;
    logic                       w_fit_split;
    logic [IMMEDIATE_WIDTH-1:0] w_fit_imm;
    logic [IMMEDIATE_WIDTH-1:0] w_fit_hi;
    logic [LO_WIDTH-1:0]        w_fit_lo;

    imm_fit_check u_fit (
        .value (req_value),
        .mode  (req_mode),
        .sel   (req_sel),
        .fits  (w_fit_fits),
        .err   (w_fit_err),
        .split (w_fit_split),
        .imm   (w_fit_imm),
        .hi    (w_fit_hi),
        .lo    (w_fit_lo)
    );

    // Accept only from IDLE and never while reset is held.
    assign req_ready = (r_state == c_st_idle) && !reset;
    assign w_fire    = r_valid & enc_ready;

    assign enc_valid = r_valid;
    assign enc_imm   = r_imm;
    assign enc_mode  = r_mode;
    assign enc_sel   = r_sel;
    assign enc_split = r_split;
    assign enc_last  = r_last;
    assign enc_err   = r_err;

    // State and output registers; reset discards any pending beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_valid <= 1'b0;
            r_imm   <= '0;
            r_mode  <= '0;
            r_sel   <= 1'b0;
            r_split <= 1'b0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_valid_nxt;
            r_imm   <= w_imm_nxt;
            r_mode  <= w_mode_nxt;
            r_sel   <= w_sel_nxt;
            r_split <= w_split_nxt;
            r_last  <= w_last_nxt;
            r_err   <= w_err_nxt;
            r_lo    <= w_lo_nxt;
        end
    end

    // Next-state and next-beat decode; everything holds unless a request is
    // accepted or the current beat is handed off.
    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_valid;
        w_imm_nxt   = r_imm;
        w_mode_nxt  = r_mode;
        w_sel_nxt   = r_sel;
        w_split_nxt = r_split;
        w_last_nxt  = r_last;
        w_err_nxt   = r_err;
        w_lo_nxt    = r_lo;

        case (r_state)
            c_st_idle: begin
                if (req_valid) begin
                    w_valid_nxt = 1'b1;
                    w_sel_nxt   = req_sel;
                    w_lo_nxt    = w_fit_lo;
                    if (w_fit_split) begin
                        w_state_nxt = c_st_hi;
                        w_imm_nxt   = w_fit_hi;
                        w_mode_nxt  = U_TYPE;
                        w_split_nxt = 1'b1;
                        w_last_nxt  = 1'b0;
                        w_err_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = c_st_one;
                        w_imm_nxt   = w_fit_fits ? w_fit_imm : '0;
                        w_mode_nxt  = req_mode;
                        w_split_nxt = 1'b0;
                        w_last_nxt  = 1'b1;
                        w_err_nxt   = w_fit_err;
                    end
                end
            end
            c_st_hi: begin
                if (w_fire) begin
                    // Low half is an ADDI: STANDARD mode, sign-extended.
                    w_state_nxt = c_st_lo;
                    w_imm_nxt   = {{c_pad_width{1'b0}}, r_lo};
                    w_mode_nxt  = STANDARD;
                    w_sel_nxt   = 1'b1;
                    w_split_nxt = 1'b1;
                    w_last_nxt  = 1'b1;
                    w_err_nxt   = 1'b0;
                end
            end
            c_st_one, c_st_lo: begin
                if (w_fire) begin
                    w_state_nxt = c_st_idle;
                    w_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_imm_enc.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_enc
// Brief    : Self-checking bench for imm_enc: directed cases, boundary sweep
//            and randomized requests against an arithmetic reference model
//            and an sz_ex reconstruction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_enc;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_value;
    logic [1:0]  req_mode;
    logic        req_sel;
    logic        enc_valid;
    logic        enc_ready;
    logic [19:0] enc_imm;
    logic [1:0]  enc_mode;
    logic        enc_sel;
    logic        enc_split;
    logic        enc_last;
    logic        enc_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct packed {
        logic [19:0] imm;
        logic [1:0]  mode;
        logic        sel;
        logic        split;
        logic        last;
        logic        err;
    } beat_t;

    typedef struct {
        int    nb;
        beat_t b0;
        beat_t b1;
    } exp_t;

    imm_enc dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_value (req_value),
        .req_mode  (req_mode),
        .req_sel   (req_sel),
        .enc_valid (enc_valid),
        .enc_ready (enc_ready),
        .enc_imm   (enc_imm),
        .enc_mode  (enc_mode),
        .enc_sel   (enc_sel),
        .enc_split (enc_split),
        .enc_last  (enc_last),
        .enc_err   (enc_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic beat_t cur();
        return {enc_imm, enc_mode, enc_sel, enc_split, enc_last, enc_err};
    endfunction

    function automatic beat_t mk(logic [19:0] imm, logic [1:0] m, logic s,
                                 logic sp, logic l, logic e);
        return {imm, m, s, sp, l, e};
    endfunction

    // The sel bit of a U_TYPE upper beat carries no meaning.
    function automatic beat_t nosel(beat_t b);
        b.sel = 1'b0;
        return b;
    endfunction

    // Reference encoder from numeric ranges.
    function automatic exp_t model(logic [31:0] v, logic [1:0] m, logic s);
        exp_t   e;
        longint sv;
        longint uv;
        bit     bad;
        sv   = longint'($signed(v));
        uv   = longint'(v);
        bad  = 0;
        e.nb = 1;
        e.b1 = '0;
        e.b0 = mk(20'h0, m, s, 1'b0, 1'b1, 1'b0);
        case (m)
            2'd0: begin
                if ((s && sv >= -2048 && sv <= 2047) || (!s && uv < 4096)) begin
                    e.b0.imm = 20'(uv % 4096);
                end else begin
                    e.nb = 2;
                    e.b0 = mk(20'(((uv + 2048) / 4096) % (1 << 20)), 2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
                    e.b1 = mk(20'(uv % 4096), 2'd0, 1'b1, 1'b1, 1'b1, 1'b0);
                end
            end
            2'd1: begin
                bad = (uv % 2 != 0) || !(s ? (sv >= -4096 && sv <= 4094) : (uv <= 8190));
                e.b0.imm = 20'((uv / 2) % 4096);
            end
            2'd2: begin
                bad = (uv % 4096) != 0;
                e.b0.imm = 20'(uv / 4096);
            end
            default: begin
                bad = (uv % 2 != 0) || sv < -(64'sd1 << 20) || sv >= (64'sd1 << 20);
                e.b0.imm = 20'((uv / 2) % (1 << 20));
            end
        endcase
        if (bad) begin
            e.b0.err = 1'b1;
            e.b0.imm = 20'h0;
        end
        return e;
    endfunction

    // What sz_ex produces from one field.
    function automatic logic [31:0] sz_ex_model(logic [19:0] imm, logic [1:0] m, logic s);
        longint x;
        case (m)
            2'd0: begin
                x = longint'(imm) % 4096;
                if (s && x >= 2048) x = x - 4096;
            end
            2'd1: begin
                x = (longint'(imm) % 4096) * 2;
                if (s && x >= 4096) x = x - 8192;
            end
            2'd2: x = longint'(imm) * 4096;
            default: begin
                x = longint'(imm) * 2;
                if (x >= (64'sd1 << 20)) x = x - (64'sd1 << 21);
            end
        endcase
        return 32'(x);
    endfunction

    // Drive one request, collect its beats, optionally stall the first beat.
    task automatic xact(input logic [31:0] v, input logic [1:0] m, input logic s,
                        input int stall, output beat_t g0, output beat_t g1,
                        output int nb, output bit stall_ok, output int occ,
                        output bit tmo);
        int    t0;
        int    w;
        beat_t snap;
        g0 = '0; g1 = '0; nb = 0; stall_ok = 1; occ = 0; tmo = 0;
        @(negedge clk);
        w = 0;
        while (req_ready !== 1'b1 && w < 10) begin
            @(negedge clk);
            w++;
        end
        if (req_ready !== 1'b1) begin
            tmo = 1;
            return;
        end
        req_valid = 1'b1; req_value = v; req_mode = m; req_sel = s;
        @(posedge clk);
        #1;
        t0 = cyc;
        req_valid = 1'b0;
        req_value = $urandom;
        req_mode  = 2'($urandom_range(0, 3));
        while (nb < 2) begin
            w = 0;
            while (enc_valid !== 1'b1 && w < 10) begin
                @(posedge clk);
                #1;
                w++;
            end
            if (enc_valid !== 1'b1) begin
                tmo = 1;
                return;
            end
            snap = cur();
            if (nb == 0) begin
                for (int k = 0; k < stall; k++) begin
                    @(posedge clk);
                    #1;
                    if (cur() !== snap || enc_valid !== 1'b1 || req_ready !== 1'b0) stall_ok = 0;
                end
            end
            enc_ready = 1'b1;
            @(posedge clk);
            #1;
            enc_ready = 1'b0;
            occ = cyc - t0 + 1;
            if (nb == 0) g0 = snap; else g1 = snap;
            nb++;
            if (snap.last === 1'b1) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({enc_valid, cur()} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h want 0", {enc_valid, cur()});
        end
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready_low: got %b want 0", req_ready);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset: got %b want 1", req_ready);
        end
    endtask

    task automatic test_standard();
        beat_t g0, g1;
        int    nb, occ;
        bit    sok, tmo;
        xact(32'hFFFFF800, 2'd0, 1'b1, 0, g0, g1, nb, sok, occ, tmo);
        checks++;
        if (tmo || nb != 1 || g0 !== mk(20'h00800, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0)) begin
            failures++;
            $display("FAIL std_sext_fit: got nb=%0d %h want nb=1 %h", nb, g0, mk(20'h00800, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0));
        end
        xact(32'h12345FFF, 2'd0, 1'b1, 0, g0, g1, nb, sok, occ, tmo);
        checks++;
        if (tmo || nb != 2 || nosel(g0) !== mk(20'h12346, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0)) begin
            failures++;
            $display("FAIL std_split_hi: got nb=%0d %h want %h", nb, nosel(g0), mk(20'h12346, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0));
        end
        checks++;
        if (g1 !== mk(20'h00FFF, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0)) begin
            failures++;
            $display("FAIL std_split_lo: got %h want %h", g1, mk(20'h00FFF, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0));
        end
        checks++;
        if (occ != 3) begin
            failures++;
            $display("FAIL std_split_occupancy: got %0d want 3", occ);
        end
        xact(32'h00000FFF, 2'd0, 1'b0, 0, g0, g1, nb, sok, occ, tmo);
        checks++;
        if (tmo || nb != 1 || g0 !== mk(20'h00FFF, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0)) begin
            failures++;
            $display("FAIL std_zext_fit: got nb=%0d %h", nb, g0);
        end
        xact(32'h00001000, 2'd0, 1'b0, 0, g0, g1, nb, sok, occ, tmo);
        checks++;
        if (tmo || nb != 2 || g0.imm !== 20'h00001 || g1.imm !== 20'h00000 || g1.sel !== 1'b1) begin
            failures++;
            $display("FAIL std_zext_split: got nb=%0d hi=%h lo=%h losel=%b want 2 00001 00000 1", nb, g0.imm, g1.imm, g1.sel);
        end
    endtask

    task automatic test_branch();
        beat_t g0, g1;
        int    nb, occ;
        bit    sok, tmo;
        xact(32'h00000FFE, 2'd1, 1'b1, 0, g0, g1, nb, sok, occ, tmo);
        checks++;
        if (tmo || nb != 1 || g0 !== mk(20'h007FF, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0)) begin
            failures++;
            $display("FAIL branch_fit: got nb=%0d %h", nb, g0);
        end
        xact(32'h00001001, 2'd1, 1'b1, 0, g0, g1, nb, sok, occ, tmo);
        checks++;
        if (tmo || nb != 1 || g0 !== mk(20'h00000, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1)) begin
            failures++;
            $display("FAIL branch_err: got nb=%0d %h", nb, g0);
        end
        xact(32'hFFFFF000, 2'd1, 1'b1, 0, g0, g1, nb, sok, occ, tmo);
        checks++;
        if (tmo || g0 !== mk(20'h00800, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0)) begin
            failures++;
            $display("FAIL branch_min: got %h", g0);
        end
        xact(32'h00002000, 2'd1, 1'b0, 0, g0, g1, nb, sok, occ, tmo);
        checks++;
        if (tmo || g0 !== mk(20'h00000, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1)) begin
            failures++;
            $display("FAIL branch_zext_range: got %h", g0);
        end
    endtask

    task automatic test_jal_utype();
        beat_t g0, g1;
        int    nb, occ;
        bit    sok, tmo;
        xact(32'hFFF00000, 2'd3, 1'b0, 0, g0, g1, nb, sok, occ, tmo);
        checks++;
        if (tmo || g0 !== mk(20'h80000, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0)) begin
            failures++;
            $display("FAIL jal_min: got %h", g0);
        end
        xact(32'h00100000, 2'd3, 1'b1, 0, g0, g1, nb, sok, occ, tmo);
        checks++;
        if (tmo || g0 !== mk(20'h00000, 2'd3, 1'b1, 1'b0, 1'b1, 1'b1)) begin
            failures++;
            $display("FAIL jal_err: got %h", g0);
        end
        xact(32'hABCDE000, 2'd2, 1'b0, 0, g0, g1, nb, sok, occ, tmo);
        checks++;
        if (tmo || g0 !== mk(20'hABCDE, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0)) begin
            failures++;
            $display("FAIL utype_fit: got %h", g0);
        end
        xact(32'hABCDE001, 2'd2, 1'b1, 0, g0, g1, nb, sok, occ, tmo);
        checks++;
        if (tmo || g0 !== mk(20'h00000, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1)) begin
            failures++;
            $display("FAIL utype_err: got %h", g0);
        end
    endtask

    task automatic test_back_to_back();
        beat_t g0, g1;
        int    nb, occ;
        bit    sok, tmo;
        for (int i = 0; i < 4; i++) begin
            xact(32'(i * 4), 2'd0, 1'b1, 0, g0, g1, nb, sok, occ, tmo);
            checks++;
            if (tmo || occ != 2 || g0.imm !== 20'(i * 4)) begin
                failures++;
                $display("FAIL b2b_single_%0d: got occ=%0d imm=%h want 2 %h", i, occ, g0.imm, 20'(i * 4));
            end
        end
    endtask

    task automatic test_backpressure();
        beat_t g0, g1;
        int    nb, occ;
        bit    sok, tmo;
        xact(32'h12345FFF, 2'd0, 1'b1, 3, g0, g1, nb, sok, occ, tmo);
        checks++;
        if (tmo || !sok) begin
            failures++;
            $display("FAIL stall_stable: got stable=%b tmo=%b want 1 0", sok, tmo);
        end
        checks++;
        if (occ != 6) begin
            failures++;
            $display("FAIL stall_occupancy: got %0d want 6", occ);
        end
        checks++;
        if (nb != 2 || g0.imm !== 20'h12346 || g0.mode !== 2'd2 || g1.imm !== 20'h00FFF || g1.mode !== 2'd0) begin
            failures++;
            $display("FAIL stall_order: got nb=%0d %h %h", nb, g0, g1);
        end
    endtask

    task automatic test_reset_mid_pair();
        beat_t g0, g1;
        int    nb, occ;
        bit    sok, tmo;
        @(negedge clk);
        req_valid = 1'b1; req_value = 32'h12345FFF; req_mode = 2'd0; req_sel = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        enc_ready = 1'b1;
        @(posedge clk);
        #1;
        enc_ready = 1'b0;
        checks++;
        if (enc_valid !== 1'b1 || enc_last !== 1'b1 || enc_mode !== 2'd0) begin
            failures++;
            $display("FAIL mid_pair_in_lo: got v=%b last=%b mode=%h want 1 1 0", enc_valid, enc_last, enc_mode);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (enc_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_pair_reset: got valid=%b ready=%b want 0 1", enc_valid, req_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (enc_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_pair_no_resume: got valid=%b want 0", enc_valid);
        end
        xact(32'h00000123, 2'd0, 1'b0, 0, g0, g1, nb, sok, occ, tmo);
        checks++;
        if (tmo || nb != 1 || g0 !== mk(20'h00123, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0)) begin
            failures++;
            $display("FAIL post_reset_req: got nb=%0d %h", nb, g0);
        end
    endtask

    task automatic test_random_and_boundary();
        logic [31:0] bvals [14] = '{32'h000007FF, 32'h00000800, 32'hFFFFF7FF, 32'h00000FFF,
                                    32'h00001000, 32'h00001FFE, 32'h00000FFE, 32'hFFFFF000,
                                    32'hFFFFEFFE, 32'h000FFFFF, 32'h000FFFFE, 32'hFFF00000,
                                    32'h7FFFFFFF, 32'h80000000};
        beat_t       g0, g1;
        int          nb, occ, stall, kind;
        bit          sok, tmo;
        logic [31:0] v, r;
        logic [1:0]  m;
        logic        s;
        exp_t        e;
        for (int i = 0; i < 14 * 8 + 300; i++) begin
            if (i < 14 * 8) begin
                v = bvals[i / 8];
                m = 2'((i % 8) / 2);
                s = 1'(i % 2);
                stall = 0;
            end else begin
                v = $urandom;
                kind = $urandom_range(0, 3);
                if (kind == 1) v = 32'($signed(v[13:0]));
                else if (kind == 2) v = 32'($signed(v[21:0]));
                else if (kind == 3) begin
                    if ($urandom_range(0, 1) == 1) v[11:0] = 12'h0;
                    else v[0] = 1'b0;
                end
                m = 2'($urandom_range(0, 3));
                s = 1'($urandom_range(0, 1));
                stall = $urandom_range(0, 2);
            end
            e = model(v, m, s);
            xact(v, m, s, stall, g0, g1, nb, sok, occ, tmo);
            checks++;
            if (tmo || nb != e.nb) begin
                failures++;
                $display("FAIL rnd_beats v=%h m=%0d s=%0d: got nb=%0d tmo=%0d want %0d", v, m, s, nb, tmo, e.nb);
            end
            checks++;
            if ((e.nb == 2 ? nosel(g0) : g0) !== (e.nb == 2 ? nosel(e.b0) : e.b0)) begin
                failures++;
                $display("FAIL rnd_beat0 v=%h m=%0d s=%0d: got %h want %h", v, m, s, g0, e.b0);
            end
            if (e.nb == 2) begin
                checks++;
                if (g1 !== e.b1) begin
                    failures++;
                    $display("FAIL rnd_beat1 v=%h: got %h want %h", v, g1, e.b1);
                end
            end
            if (!e.b0.err) begin
                r = sz_ex_model(g0.imm, g0.mode, g0.sel)
                  + (nb == 2 ? sz_ex_model(g1.imm, g1.mode, g1.sel) : 32'h0);
                checks++;
                if (r !== v) begin
                    failures++;
                    $display("FAIL rnd_reconstruct m=%0d s=%0d: got %h want %h", m, s, r, v);
                end
            end
            checks++;
            if (occ != e.nb + 1 + stall || !sok) begin
                failures++;
                $display("FAIL rnd_timing v=%h: got occ=%0d stable=%b want %0d 1", v, occ, sok, e.nb + 1 + stall);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_value = '0;
        req_mode  = '0;
        req_sel   = 1'b0;
        enc_ready = 1'b0;
        test_reset();
        test_standard();
        test_branch();
        test_jal_utype();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_pair();
        test_random_and_boundary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
